// File: rtl/gol_generation_scheduler_pkg.sv
// Shared state encodings, default parameters and tick-period helper for the
// Game of Life generation scheduler.
package gol_generation_scheduler_pkg;

  // Scheduler FSM encoding
  localparam logic [1:0] ST_PAUSED = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] ST_LOAD   = 2'd3;

  // Defaults: ~8 generations/s at top speed from a 12.5 MHz-ish tick base
  localparam int TICK_BASE_DEF    = 1562500;
  localparam int SPEED_MAX_DEF    = 7;
  localparam int SPEED_INIT_DEF   = 4;
  localparam int STEP_TIMEOUT_DEF = 65535;
  localparam int GEN_W_DEF        = 16;

  // Tick period in clk cycles for a given speed index
  function automatic int tick_period(input int base, input int smax, input int spd);
    return base << (smax - spd);
  endfunction

endpackage

// File: rtl/gol_generation_scheduler_tick_divider.sv
// Tick divider: free-running counter compared against a speed-scaled period.
// The owner clears it outside RUN and whenever a tick is taken.
module gol_generation_scheduler_tick_divider
  import gol_generation_scheduler_pkg::*;
#(
  parameter int TICK_BASE = TICK_BASE_DEF,
  parameter int SPEED_MAX = SPEED_MAX_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic [$clog2(SPEED_MAX+1)-1:0] speed,
  output logic                           tick
);

  localparam int SW = $clog2(SPEED_MAX + 1);
  // Sized for the slowest period; the counter never runs past one period in RUN.
  localparam int CW = $clog2(tick_period(TICK_BASE, SPEED_MAX, 0) + 1);
  localparam logic [SW-1:0] SMAX = SW'(SPEED_MAX);

  logic [CW-1:0] cnt;
  logic [CW-1:0] period;

  // Period follows speed combinationally so a speed change hits the next compare
  always_comb begin
    period = CW'(TICK_BASE) << (SMAX - speed);
  end

  // >= rather than == so a shrinking period past the count still fires at once
  assign tick = (cnt >= (period - CW'(1)));

  // Count every cycle unless told to hold at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else          cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/gol_generation_scheduler.sv
// Generation scheduler: paces step requests to the next-state engine, handles
// pause/single-step/speed, and commits edited grids into the engine.
module gol_generation_scheduler
  import gol_generation_scheduler_pkg::*;
#(
  parameter int TICK_BASE    = TICK_BASE_DEF,
  parameter int SPEED_MAX    = SPEED_MAX_DEF,
  parameter int SPEED_INIT   = SPEED_INIT_DEF,
  parameter int STEP_TIMEOUT = STEP_TIMEOUT_DEF,
  parameter int GEN_W        = GEN_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pause_req,
  input  logic                           single_step,
  input  logic                           edit_commit,
  input  logic                           speed_up,
  input  logic                           speed_down,
  input  logic                           step_done,
  output logic                           step_start,
  output logic                           grid_load,
  output logic [GEN_W-1:0]               gen_count,
  output logic [$clog2(SPEED_MAX+1)-1:0] speed,
  output logic                           busy,
  output logic                           step_timeout
);

  localparam int SW = $clog2(SPEED_MAX + 1);
  localparam int WW = $clog2(STEP_TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LIM  = WW'(STEP_TIMEOUT - 1);
  localparam logic [SW-1:0] SPD_TOP = SW'(SPEED_MAX);
  localparam logic [SW-1:0] SPD_RST = SW'(SPEED_INIT);

  logic [1:0]    state, nxt;
  logic          edit_pending;
  logic          from_single;
  logic [WW-1:0] wd;
  logic          tick;
  logic          done_ev;
  logic          abort_ev;
  logic          cnt_clr;

  // Tick counter only runs while we stay in RUN; entering or leaving RUN zeroes it
  assign cnt_clr = (state != ST_RUN) || (nxt != ST_RUN);

  gol_generation_scheduler_tick_divider #(
    .TICK_BASE (TICK_BASE),
    .SPEED_MAX (SPEED_MAX)
  ) u_div (
    .clk   (clk),
    .rst   (reset),
    .clr   (cnt_clr),
    .speed (speed),
    .tick  (tick)
  );

  // Next-state decode; edit_pending always wins so a commit is never starved
  always_comb begin
    nxt      = state;
    done_ev  = 1'b0;
    abort_ev = 1'b0;
    case (state)
      ST_PAUSED: begin
        if (edit_pending)    nxt = ST_LOAD;
        else if (single_step) nxt = ST_STEP;
        else if (!pause_req) nxt = ST_RUN;
      end
      ST_RUN: begin
        if (edit_pending)   nxt = ST_LOAD;
        else if (pause_req) nxt = ST_PAUSED;
        else if (tick)      nxt = ST_STEP;
      end
      ST_STEP: begin
        done_ev  = step_done;
        abort_ev = !step_done && (wd == WD_LIM);
        if (done_ev || abort_ev) begin
          if (edit_pending)                  nxt = ST_LOAD;
          else if (pause_req || from_single) nxt = ST_PAUSED;
          else                               nxt = ST_RUN;
        end
      end
      ST_LOAD: begin
        nxt = pause_req ? ST_PAUSED : ST_RUN;
      end
      default: nxt = ST_PAUSED;
    endcase
  end

  // State register plus registered strobes and busy, all decoded from nxt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_PAUSED;
      step_start <= 1'b0;
      grid_load  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= nxt;
      step_start <= (nxt == ST_STEP) && (state != ST_STEP);
      grid_load  <= (nxt == ST_LOAD);
      busy       <= (nxt == ST_STEP) || (nxt == ST_LOAD);
    end
  end

  // Watchdog: zero on STEP entry, counts each STEP cycle; sticky flag on abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd           <= '0;
      step_timeout <= 1'b0;
    end else begin
      wd           <= (state == ST_STEP) ? wd + WW'(1) : '0;
      step_timeout <= step_timeout | abort_ev;
    end
  end

  // Generation counter: bump on accepted done, wrap naturally, clear on load
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                gen_count <= '0;
    else if (state == ST_LOAD) gen_count <= '0;
    else if (done_ev)         gen_count <= gen_count + GEN_W'(1);
  end

  // A commit landing in the LOAD cycle re-arms for another load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) edit_pending <= 1'b0;
    else       edit_pending <= edit_commit | (edit_pending & (state != ST_LOAD));
  end

  // Remember whether the current step came from single_step so it parks in PAUSED
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     from_single <= 1'b0;
    else if (state == ST_PAUSED && nxt == ST_STEP) from_single <= 1'b1;
    else if (state == ST_RUN && nxt == ST_STEP)    from_single <= 1'b0;
  end

  // Speed index, saturating; simultaneous up/down cancels
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      speed <= SPD_RST;
    else if (speed_up && !speed_down && speed != SPD_TOP)
      speed <= speed + SW'(1);
    else if (speed_down && !speed_up && speed != '0)
      speed <= speed - SW'(1);
  end

endmodule

// File: doc/gol_generation_scheduler.md
Name: gol_generation_scheduler

Overview:
- Sequences Game of Life generations by issuing one step request per tick to the next-state engine and waiting for completion.
- Lets edited grids from the cursor/edit controller be committed into the engine.
- Handles run/pause, single-step and speed selection.
- Sits between the user controller (pause, edit commit) and the grid compute engine (step handshake, grid load).

Parameters:
- TICK_BASE, 1562500, clk cycles per tick at maximum speed; must be >= 1.
- SPEED_MAX, 7, highest speed index; tick period = TICK_BASE << (SPEED_MAX - speed).
- SPEED_INIT, 4, speed index after reset.
- STEP_TIMEOUT, 65535, cycles in STEP without step_done before abort.
- GEN_W, 16, width of generation counter.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- pause_req  in  1  level; 1 = paused, 0 = running.
- single_step  in  1  pulse; advance one generation; honoured only in PAUSED.
- edit_commit  in  1  pulse; editor grid ready to load into engine.
- speed_up  in  1  pulse; speed +1, saturating.
- speed_down  in  1  pulse; speed -1, saturating.
- step_done  in  1  pulse from engine; current generation complete.
- step_start  out  1  one-cycle pulse; engine computes next generation.
- grid_load  out  1  one-cycle pulse; engine latches editor grid.
- gen_count  out  GEN_W  generations since reset or last load.
- speed  out  $clog2(SPEED_MAX+1)  current speed index.
- busy  out  1  high in STEP or LOAD.
- step_timeout  out  1  sticky; set on a watchdog abort.

Behaviour:
- Reset values:
  - state = PAUSED
  - step_start = 0, grid_load = 0, busy = 0, step_timeout = 0
  - gen_count = 0, speed = SPEED_INIT
  - tick counter = 0, watchdog = 0
  - edit_pending = 0, from_single = 0
- Reset mid-STEP abandons the step; no step_start is reissued.
- States and transitions, priority order top to bottom:
  - PAUSED:
    - edit_pending -> LOAD
    - else single_step -> STEP, from_single = 1
    - else !pause_req -> RUN, tick counter = 0
  - RUN (tick counter increments every cycle):
    - edit_pending -> LOAD (also beats a same-cycle tick)
    - else pause_req -> PAUSED
    - else counter >= period-1 -> STEP, counter = 0, from_single = 0
  - STEP:
    - step_start = 1 in the first STEP cycle only (registered).
    - Watchdog counts from 0.
    - On step_done: gen_count+1, wrapping all-ones -> 0. Next state: LOAD if edit_pending; else PAUSED if pause_req or from_single; else RUN.
    - Watchdog reaching STEP_TIMEOUT-1 without done: step_timeout = 1, gen_count unchanged, same next-state rule as done.
  - LOAD:
    - grid_load = 1 for exactly one cycle.
    - gen_count = 0, edit_pending = 0.
    - Next state: PAUSED if pause_req else RUN, tick counter = 0.
- Input handling:
  - edit_commit sets edit_pending in any state, including the cycle it is consumed (re-arms). Multiple commits collapse into one load.
  - step_done outside STEP is ignored. single_step outside PAUSED is ignored.
  - Pausing during STEP lets the step finish; no new step_start is issued.
- Speed:
  - speed_up and speed_down in the same cycle -> no change.
  - Saturates at 0 and SPEED_MAX.
  - A new period applies at the next compare. If counter >= new period-1, the tick fires on the next cycle.
- Latency:
  - single_step at cycle n -> step_start at n+1.
  - In RUN, step_start is period+1 cycles after RUN entry; steady-state spacing = period + engine latency + 1.
- busy is a registered decode of state.
- step_timeout clears only on reset.

Decomposition:
- types.sv: sched_state_t enum {PAUSED, RUN, STEP, LOAD}, SPEED_MAX, SPEED_INIT, default TICK_BASE.
- Sub-module tick_divider: counter, speed shift, tick compare, clear input. Top holds the FSM, watchdog, gen_count and speed register.

Test Plan (TICK_BASE=4, STEP_TIMEOUT=16, engine model returns step_done 3 cycles after step_start):
- Reset, pause_req=1, single_step pulse at cycle 10 -> step_start at 11, step_done at 14, gen_count=1, state PAUSED, no further step_start for 100 cycles.
- pause_req=0, speed=7 -> step_start repeats every 4+3+1=8 cycles; after 5 steps gen_count=5. Then speed_down x2 -> spacing becomes 16+3+1=20.
- Speed saturation: speed_up x10 from 4 -> speed=7; speed_up+speed_down same cycle -> stays 7; speed_down x10 -> 0.
- edit_commit during STEP -> grid_load one cycle after step_done, gen_count=0 after load, busy high throughout; second edit_commit in the same STEP -> exactly one grid_load.
- Engine withholds step_done -> step_timeout=1 after 16 STEP cycles, gen_count unchanged, returns to RUN; a late step_done is ignored.
- Assert reset while in STEP -> all outputs at reset values immediately (asynchronous), speed=4, step_timeout=0.
